// File: rtl/lms_update_sequencer_if.sv
// Update-request bus between the LMS sequencer and the shared complex weight-update MAC.
interface lms_update_sequencer_if #(
   parameter int unsigned IDX_W = 2
) ();
   logic                    upd_valid;
   logic                    upd_ready;
   logic [IDX_W-1:0]        upd_idx;
   logic signed [17:0]      upd_eI;
   logic signed [17:0]      upd_eQ;
   logic                    upd_last;

   modport master (
      output upd_valid, upd_idx, upd_eI, upd_eQ, upd_last,
      input  upd_ready
   );

   modport slave (
      input  upd_valid, upd_idx, upd_eI, upd_eQ, upd_last,
      output upd_ready
   );
endinterface

// File: rtl/lms_update_sequencer.sv
// Sequences LMS weight updates: one error sample fans out to NUM_ELEM indexed MAC requests,
// then iteration/convergence bookkeeping decides whether to wait for more errors or finish.
module lms_update_sequencer #(
   parameter int unsigned NUM_ELEM    = 4,
   parameter int unsigned IDX_W       = 2,
   parameter int unsigned MAX_ITER    = 1024,
   parameter int unsigned ITER_W      = 11,
   parameter int unsigned TRAIN_LEN   = 64,
   parameter int unsigned CONV_THRESH = 512,
   parameter int unsigned CONV_COUNT  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     err_valid,
   input  logic signed [17:0]       econjI,
   input  logic signed [17:0]       econjQ,
   lms_update_sequencer_if.master   upd,
   output logic                     ref_sel,
   output logic                     busy,
   output logic [ITER_W-1:0]        iter_cnt,
   output logic                     converged,
   output logic                     overrun,
   output logic                     done
);

   localparam int unsigned DW    = 18;
   localparam int unsigned MAG_W = 19;
   localparam int unsigned RUN_W = $clog2(CONV_COUNT + 1);

   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_ELEM - 1);
   localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
   localparam logic [ITER_W-1:0] TRAIN_AT   = ITER_W'(TRAIN_LEN);
   localparam logic [RUN_W-1:0]  RUN_TARGET = RUN_W'(CONV_COUNT);
   localparam logic [MAG_W-1:0]  THRESH     = MAG_W'(CONV_THRESH);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_ERR = 3'd1,
      S_ISSUE    = 3'd2,
      S_CHECK    = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t                state_q, state_d;

   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic signed [DW-1:0]  ei_q, ei_d;
   logic signed [DW-1:0]  eq_q, eq_d;
   logic [MAG_W-1:0]      mag_q, mag_d;
   logic [RUN_W-1:0]      run_q, run_d;
   logic [ITER_W-1:0]     iter_q, iter_d;
   logic                  ref_q, ref_d;
   logic                  conv_q, conv_d;
   logic                  ovr_q, ovr_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  xfer;
   logic                  below;
   logic                  conv_hit;
   logic                  max_hit;
   logic [ITER_W-1:0]     iter_inc;
   logic [RUN_W-1:0]      run_inc;
   logic [MAG_W-1:0]      mag_in;

   // Magnitude of a two's-complement sample; -2^17 maps to 2^17 without saturating.
   function automatic logic [MAG_W-1:0] abs_ext(input logic [DW-1:0] v);
      logic [DW-1:0] m;
      m = v[DW-1] ? (~v + DW'(1)) : v;
      return MAG_W'(m);
   endfunction

   assign xfer     = valid_q && upd.upd_ready;
   assign mag_in   = abs_ext(econjI) + abs_ext(econjQ);
   assign below    = (mag_q < THRESH);
   assign iter_inc = iter_q + ITER_W'(1);
   assign run_inc  = run_q + RUN_W'(1);
   assign conv_hit = below && (run_inc == RUN_TARGET);
   assign max_hit  = (iter_inc == ITER_LIMIT);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; abort returns to IDLE from anywhere.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start) state_d = S_WAIT_ERR;
         S_WAIT_ERR: if (err_valid) state_d = S_ISSUE;
         S_ISSUE:    if (xfer && (idx_q == LAST_IDX)) state_d = S_CHECK;
         S_CHECK:    state_d = (conv_hit || max_hit) ? S_DONE : S_WAIT_ERR;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   // Next values of the datapath and output registers.
   always_comb begin
      idx_d  = idx_q;
      ei_d   = ei_q;
      eq_d   = eq_q;
      mag_d  = mag_q;
      run_d  = run_q;
      iter_d = iter_q;
      ref_d  = ref_q;
      conv_d = conv_q;
      ovr_d  = ovr_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               iter_d = '0;
               run_d  = '0;
               conv_d = 1'b0;
               ovr_d  = 1'b0;
               ref_d  = 1'b0;
            end
         end
         S_WAIT_ERR: begin
            if (err_valid && !abort) begin
               ei_d  = econjI;
               eq_d  = econjQ;
               mag_d = mag_in;
               idx_d = '0;
            end
         end
         S_ISSUE: begin
            if (xfer && !abort && (idx_q != LAST_IDX)) idx_d = idx_q + IDX_W'(1);
         end
         S_CHECK: begin
            if (!abort) begin
               iter_d = iter_inc;
               run_d  = below ? run_inc : '0;
               if (iter_inc >= TRAIN_AT) ref_d = 1'b1;
               if (conv_hit) conv_d = 1'b1;
            end
         end
         default: ;
      endcase
      // Samples arriving while the MAC loop is occupied are dropped and flagged.
      if (err_valid && ((state_q == S_ISSUE) || (state_q == S_CHECK) || (state_q == S_DONE)))
         ovr_d = 1'b1;
      valid_d = (state_d == S_ISSUE);
      last_d  = valid_d && (idx_d == LAST_IDX);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         idx_q   <= '0;
         ei_q    <= '0;
         eq_q    <= '0;
         mag_q   <= '0;
         run_q   <= '0;
         iter_q  <= '0;
         ref_q   <= 1'b0;
         conv_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         ei_q    <= ei_d;
         eq_q    <= eq_d;
         mag_q   <= mag_d;
         run_q   <= run_d;
         iter_q  <= iter_d;
         ref_q   <= ref_d;
         conv_q  <= conv_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign upd.upd_valid = valid_q;
   assign upd.upd_idx   = idx_q;
   assign upd.upd_eI    = ei_q;
   assign upd.upd_eQ    = eq_q;
   assign upd.upd_last  = last_q;
   assign ref_sel       = ref_q;
   assign busy          = busy_q;
   assign iter_cnt      = iter_q;
   assign converged     = conv_q;
   assign overrun       = ovr_q;
   assign done          = done_q;

endmodule

// File: tb/tb_lms_update_sequencer.sv
// Directed bench for lms_update_sequencer with NUM_ELEM=4 and default thresholds.
module tb_lms_update_sequencer;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               abort;
   logic               err_valid;
   logic signed [17:0] econjI;
   logic signed [17:0] econjQ;
   logic               ref_sel;
   logic               busy;
   logic [10:0]        iter_cnt;
   logic               converged;
   logic               overrun;
   logic               done;

   int errors = 0;
   int checks = 0;

   lms_update_sequencer_if #(.IDX_W(2)) upd ();

   lms_update_sequencer #(
      .NUM_ELEM(4), .IDX_W(2), .MAX_ITER(1024), .ITER_W(11),
      .TRAIN_LEN(64), .CONV_THRESH(512), .CONV_COUNT(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .err_valid(err_valid), .econjI(econjI), .econjQ(econjQ),
      .upd(upd),
      .ref_sel(ref_sel), .busy(busy), .iter_cnt(iter_cnt),
      .converged(converged), .overrun(overrun), .done(done)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // One full iteration with upd_ready high: error cycle, 4 ISSUE cycles, 1 CHECK cycle.
   task automatic run_iter(input logic signed [17:0] i, input logic signed [17:0] q);
      err_valid = 1'b1; econjI = i; econjQ = q;
      tick();
      err_valid = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (upd.upd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", upd.upd_valid); end
      checks++; if (iter_cnt !== 11'd0) begin errors++; $display("FAIL reset_iter: got %0d expected 0", iter_cnt); end
      checks++; if ({converged, overrun, done, ref_sel, upd.upd_last} !== 5'b0) begin errors++;
         $display("FAIL reset_flags: got %b expected 00000", {converged, overrun, done, ref_sel, upd.upd_last}); end
      checks++; if ({upd.upd_eI, upd.upd_eQ} !== 36'd0) begin errors++;
         $display("FAIL reset_err: got %0d/%0d expected 0/0", upd.upd_eI, upd.upd_eQ); end
   endtask

   task automatic test_basic();
      do_reset();
      do_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b expected 1", busy); end
      err_valid = 1'b1; econjI = 18'sd100; econjQ = -18'sd50;
      tick();
      err_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++; if (upd.upd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %0b expected 1", k, upd.upd_valid); end
         checks++; if (upd.upd_idx !== 2'(k)) begin errors++; $display("FAIL basic_idx[%0d]: got %0d expected %0d", k, upd.upd_idx, k); end
         checks++; if (upd.upd_last !== (k == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %0b expected %0b", k, upd.upd_last, (k == 3)); end
         checks++; if (upd.upd_eI !== 18'sd100 || upd.upd_eQ !== -18'sd50) begin errors++;
            $display("FAIL basic_err[%0d]: got %0d/%0d expected 100/-50", k, upd.upd_eI, upd.upd_eQ); end
         tick();
      end
      checks++; if (upd.upd_valid !== 1'b0) begin errors++; $display("FAIL basic_check_valid: got %0b expected 0", upd.upd_valid); end
      tick();
      checks++; if (iter_cnt !== 11'd1) begin errors++; $display("FAIL basic_iter: got %0d expected 1", iter_cnt); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %0b%0b expected 10", busy, done); end
      // start while busy is ignored
      do_start();
      checks++; if (iter_cnt !== 11'd1 || busy !== 1'b1) begin errors++;
         $display("FAIL start_while_busy: got iter=%0d busy=%0b expected iter=1 busy=1", iter_cnt, busy); end
   endtask

   task automatic test_backpressure();
      logic pat [4];
      int   exp_idx;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      exp_idx = 0;
      do_reset();
      do_start();
      err_valid = 1'b1; econjI = 18'sd7; econjQ = -18'sd3;
      tick();
      err_valid = 1'b0;
      for (int j = 0; j < 40 && exp_idx < 4; j++) begin
         upd.upd_ready = pat[j % 4];
         if (upd.upd_valid) begin
            checks++; if (upd.upd_idx !== 2'(exp_idx)) begin errors++;
               $display("FAIL bp_idx[cyc %0d]: got %0d expected %0d", j, upd.upd_idx, exp_idx); end
            checks++; if (upd.upd_eI !== 18'sd7 || upd.upd_eQ !== -18'sd3) begin errors++;
               $display("FAIL bp_err[cyc %0d]: got %0d/%0d expected 7/-3", j, upd.upd_eI, upd.upd_eQ); end
            if (upd.upd_ready) exp_idx++;
         end
         tick();
      end
      upd.upd_ready = 1'b1;
      checks++; if (exp_idx !== 4) begin errors++; $display("FAIL bp_transfers: got %0d expected 4", exp_idx); end
      checks++; if (upd.upd_valid !== 1'b0) begin errors++; $display("FAIL bp_after_last: got %0b expected 0", upd.upd_valid); end
      tick();
      checks++; if (iter_cnt !== 11'd1) begin errors++; $display("FAIL bp_iter: got %0d expected 1", iter_cnt); end
   endtask

   task automatic test_convergence();
      do_reset();
      do_start();
      for (int n = 1; n <= 16; n++) begin
         run_iter(18'sd10, 18'sd10);
         if (n == 15) begin
            checks++; if (converged !== 1'b0 || done !== 1'b0) begin errors++;
               $display("FAIL conv_early: got conv=%0b done=%0b expected 0 0", converged, done); end
         end
      end
      checks++; if (done !== 1'b1 || converged !== 1'b1) begin errors++;
         $display("FAIL conv16: got done=%0b conv=%0b expected 1 1", done, converged); end
      checks++; if (iter_cnt !== 11'd16) begin errors++; $display("FAIL conv16_iter: got %0d expected 16", iter_cnt); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0 || converged !== 1'b1) begin errors++;
         $display("FAIL conv16_after: got done=%0b busy=%0b conv=%0b expected 0 0 1", done, busy, converged); end
      // second run, large error at iteration 10 resets the run counter
      do_start();
      checks++; if (converged !== 1'b0) begin errors++; $display("FAIL conv_clear: got %0b expected 0", converged); end
      for (int n = 1; n <= 26; n++) begin
         if (n == 10) run_iter(18'sd600, 18'sd0);
         else         run_iter(18'sd10, 18'sd10);
         if (n == 25) begin
            checks++; if (converged !== 1'b0 || done !== 1'b0) begin errors++;
               $display("FAIL conv26_early: got conv=%0b done=%0b expected 0 0", converged, done); end
         end
      end
      checks++; if (done !== 1'b1 || converged !== 1'b1 || iter_cnt !== 11'd26) begin errors++;
         $display("FAIL conv26: got done=%0b conv=%0b iter=%0d expected 1 1 26", done, converged, iter_cnt); end
      tick();
   endtask

   task automatic test_threshold();
      do_reset();
      do_start();
      for (int n = 1; n <= 16; n++) run_iter(-18'sd256, 18'sd256);
      checks++; if (converged !== 1'b0 || done !== 1'b0) begin errors++;
         $display("FAIL thresh_512: got conv=%0b done=%0b expected 0 0", converged, done); end
      for (int n = 1; n <= 16; n++) run_iter(18'sd255, -18'sd256);
      checks++; if (converged !== 1'b1 || done !== 1'b1 || iter_cnt !== 11'd32) begin errors++;
         $display("FAIL thresh_511: got conv=%0b done=%0b iter=%0d expected 1 1 32", converged, done, iter_cnt); end
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      do_start();
      for (int n = 1; n <= 1024; n++) begin
         run_iter(-18'sd131072, -18'sd131072);
         if (n == 63) begin
            checks++; if (ref_sel !== 1'b0) begin errors++; $display("FAIL ref_sel_63: got %0b expected 0", ref_sel); end
         end
         if (n == 64) begin
            checks++; if (ref_sel !== 1'b1) begin errors++; $display("FAIL ref_sel_64: got %0b expected 1", ref_sel); end
         end
         if (n == 1023) begin
            checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++;
               $display("FAIL timeout_1023: got done=%0b busy=%0b expected 0 1", done, busy); end
         end
      end
      checks++; if (done !== 1'b1 || converged !== 1'b0 || iter_cnt !== 11'd1024) begin errors++;
         $display("FAIL timeout_1024: got done=%0b conv=%0b iter=%0d expected 1 0 1024", done, converged, iter_cnt); end
      tick();
      checks++; if (busy !== 1'b0 || ref_sel !== 1'b1 || iter_cnt !== 11'd1024) begin errors++;
         $display("FAIL timeout_hold: got busy=%0b ref=%0b iter=%0d expected 0 1 1024", busy, ref_sel, iter_cnt); end
   endtask

   task automatic test_overrun_abort();
      do_reset();
      err_valid = 1'b1; econjI = 18'sd9; econjQ = 18'sd9;
      tick();
      err_valid = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_idle: got %0b expected 0", overrun); end
      do_start();
      err_valid = 1'b1; econjI = 18'sd1; econjQ = 18'sd2;
      tick();
      upd.upd_ready = 1'b0;
      econjI = 18'sd55; econjQ = 18'sd66;
      tick();
      err_valid = 1'b0;
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_issue: got %0b expected 1", overrun); end
      checks++; if (upd.upd_eI !== 18'sd1 || upd.upd_eQ !== 18'sd2) begin errors++;
         $display("FAIL overrun_latch: got %0d/%0d expected 1/2", upd.upd_eI, upd.upd_eQ); end
      checks++; if (upd.upd_valid !== 1'b1 || upd.upd_idx !== 2'd0) begin errors++;
         $display("FAIL overrun_stall: got valid=%0b idx=%0d expected 1 0", upd.upd_valid, upd.upd_idx); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (upd.upd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++;
         $display("FAIL abort_stop: got valid=%0b busy=%0b done=%0b expected 0 0 0", upd.upd_valid, busy, done); end
      tick();
      checks++; if (done !== 1'b0 || iter_cnt !== 11'd0) begin errors++;
         $display("FAIL abort_nodone: got done=%0b iter=%0d expected 0 0", done, iter_cnt); end
      upd.upd_ready = 1'b1;
      do_start();
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %0b expected 0", overrun); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      do_start();
      run_iter(18'sd3, 18'sd4);
      run_iter(18'sd3, 18'sd4);
      err_valid = 1'b1; econjI = -18'sd77; econjQ = 18'sd88;
      tick();
      err_valid = 1'b0;
      checks++; if (upd.upd_valid !== 1'b1 || iter_cnt !== 11'd2) begin errors++;
         $display("FAIL mid_pre: got valid=%0b iter=%0d expected 1 2", upd.upd_valid, iter_cnt); end
      do_reset();
      checks++; if ({upd.upd_valid, busy, done, upd.upd_last} !== 4'b0 || iter_cnt !== 11'd0 || {upd.upd_eI, upd.upd_eQ} !== 36'd0) begin errors++;
         $display("FAIL mid_reset: got flags=%b iter=%0d err=%0d/%0d expected 0000 0 0/0",
                  {upd.upd_valid, busy, done, upd.upd_last}, iter_cnt, upd.upd_eI, upd.upd_eQ); end
      do_start();
      checks++; if (iter_cnt !== 11'd0 || busy !== 1'b1) begin errors++;
         $display("FAIL mid_restart: got iter=%0d busy=%0b expected 0 1", iter_cnt, busy); end
      run_iter(18'sd1, 18'sd1);
      checks++; if (iter_cnt !== 11'd1) begin errors++; $display("FAIL mid_restart_iter: got %0d expected 1", iter_cnt); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; err_valid = 1'b0;
      econjI = '0; econjQ = '0; upd.upd_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_convergence();
      test_threshold();
      test_timeout();
      test_overrun_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
